// File: rtl/icache_pkg.sv
// Shared types and derived widths for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS,
    ST_REFILL,
    ST_RESP
  } icache_state_t;

  localparam int ICACHE_WORD_W = 32;

  // Widths for the default geometry (64 sets x 4 words)
  localparam int ICACHE_OW = 2;
  localparam int ICACHE_IW = 6;
  localparam int ICACHE_TW = 32 - 2 - ICACHE_OW - ICACHE_IW;

  function automatic int icache_tag_w(input int sets, input int line_words);
    return 30 - $clog2(sets) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Line data storage: one synchronous write port, one combinational read port.
module icache_data_ram
  import icache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                            clk,
  input  logic                            i_we,
  input  logic [$clog2(SETS)-1:0]         i_widx,
  input  logic [$clog2(LINE_WORDS)-1:0]   i_wword,
  input  logic [ICACHE_WORD_W-1:0]        i_wdata,
  input  logic [$clog2(SETS)-1:0]         i_ridx,
  input  logic [$clog2(LINE_WORDS)-1:0]   i_rword,
  output logic [ICACHE_WORD_W-1:0]        o_rdata
);

  logic [ICACHE_WORD_W-1:0] r_mem [SETS*LINE_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[{i_widx, i_wword}] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[{i_ridx, i_rword}];

endmodule

// File: rtl/icache.sv
// Blocking direct-mapped instruction cache with a read-only burst refill port.
module icache
  import icache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        icache_req,
  input  logic [31:0] icache_addr,
  input  logic        icache_uncached,
  output logic        icache_addr_ok,
  output logic        icache_data_ok,
  output logic [31:0] icache_rdata,
  output logic        mem_arvalid,
  output logic [31:0] mem_araddr,
  output logic [3:0]  mem_arlen,
  input  logic        mem_arready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rlast,
  output logic        mem_rready
);

  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(SETS);
  localparam int TW = icache_tag_w(SETS, LINE_WORDS);
  localparam logic [3:0] ARLEN_LINE = 4'(LINE_WORDS - 1);

  icache_state_t   r_state;
  logic [31:2]     r_addr;
  logic            r_uncached;
  logic [OW-1:0]   r_beat;
  logic [31:0]     r_resp;
  logic [SETS-1:0] r_valid;
  logic [TW-1:0]   r_tag [SETS];

  logic [OW-1:0] w_offset;
  logic [IW-1:0] w_index;
  logic [TW-1:0] w_tag;
  logic          w_hit;
  logic          w_accept;
  logic          w_beat_fire;
  logic          w_ram_we;
  logic          w_tag_we;
  logic [31:0]   w_ram_rdata;
  logic          w_unused;

  assign w_offset = r_addr[2 +: OW];
  assign w_index  = r_addr[2+OW +: IW];
  assign w_tag    = r_addr[31 -: TW];
  assign w_unused = ^icache_addr[1:0];

  assign w_hit = (r_state == ST_LOOKUP) && !r_uncached &&
                 r_valid[w_index] && (r_tag[w_index] == w_tag);

  // A hit frees the cache in the same cycle, so back-to-back hits pipeline.
  assign w_accept       = icache_req && ((r_state == ST_IDLE) || w_hit);
  assign icache_addr_ok = w_accept;
  assign icache_data_ok = w_hit || (r_state == ST_RESP);
  assign icache_rdata   = w_hit ? w_ram_rdata :
                          (r_state == ST_RESP) ? r_resp : 32'h0;

  assign mem_arvalid = (r_state == ST_MISS);
  assign mem_araddr  = (r_state != ST_MISS) ? 32'h0 :
                       r_uncached ? {r_addr[31:2], 2'b00} :
                                    {r_addr[31:2+OW], {(OW+2){1'b0}}};
  assign mem_arlen   = ((r_state == ST_MISS) && !r_uncached) ? ARLEN_LINE : 4'h0;
  assign mem_rready  = (r_state == ST_REFILL);

  assign w_beat_fire = (r_state == ST_REFILL) && mem_rvalid && !reset;
  assign w_ram_we    = w_beat_fire && !r_uncached;
  assign w_tag_we    = w_ram_we && mem_rlast;

  icache_data_ram #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS)
  ) u_data_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_widx  (w_index),
    .i_wword (r_beat),
    .i_wdata (mem_rdata),
    .i_ridx  (w_index),
    .i_rword (w_offset),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (w_tag_we) begin
      r_tag[w_index] <= w_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_uncached <= 1'b0;
      r_beat     <= '0;
      r_resp     <= '0;
      r_valid    <= '0;
    end else begin
      if (w_accept) begin
        r_addr     <= icache_addr[31:2];
        r_uncached <= icache_uncached;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) r_state <= ST_LOOKUP;
        end
        ST_LOOKUP: begin
          if (w_hit) r_state <= w_accept ? ST_LOOKUP : ST_IDLE;
          else       r_state <= ST_MISS;
        end
        ST_MISS: begin
          if (mem_arready) begin
            r_state <= ST_REFILL;
            r_beat  <= '0;
          end
        end
        ST_REFILL: begin
          if (mem_rvalid) begin
            r_beat <= r_beat + 1'b1;
            if (r_uncached || (r_beat == w_offset)) r_resp <= mem_rdata;
            // A short burst still validates the line; rlast is trusted.
            if (mem_rlast) begin
              if (!r_uncached) r_valid[w_index] <= 1'b1;
              r_state <= ST_RESP;
            end
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Randomized self-checking bench for icache against a transaction-level cache model.
module tb_icache;

  localparam int SETS = 64;
  localparam int LW   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        icache_req, icache_uncached, icache_addr_ok, icache_data_ok;
  logic [31:0] icache_addr, icache_rdata;
  logic        mem_arvalid, mem_arready, mem_rvalid, mem_rlast, mem_rready;
  logic [31:0] mem_araddr, mem_rdata;
  logic [3:0]  mem_arlen;

  icache #(.SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk             (clk),
    .reset           (reset),
    .icache_req      (icache_req),
    .icache_addr     (icache_addr),
    .icache_uncached (icache_uncached),
    .icache_addr_ok  (icache_addr_ok),
    .icache_data_ok  (icache_data_ok),
    .icache_rdata    (icache_rdata),
    .mem_arvalid     (mem_arvalid),
    .mem_araddr      (mem_araddr),
    .mem_arlen       (mem_arlen),
    .mem_arready     (mem_arready),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata),
    .mem_rlast       (mem_rlast),
    .mem_rready      (mem_rready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: what the cache holds, plus the single outstanding request.
  bit          ref_valid [SETS];
  logic [31:0] ref_tag   [SETS];
  bit          busy, o_unc, o_hit, o_ar_done, o_refill_done;
  logic [31:0] o_addr, o_exp;
  int          o_age, o_arw, o_beat, o_acc_cyc;
  int          ar_lo = 0, ar_hi = 0, gap_pct = 0;
  int          last_lat;
  logic [31:0] last_rdata;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w[31:4] == 28'h1FC0000) return 32'hA0 + 32'(w[3:2]);
    return (w * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // Uncached space is a different device view of the same address.
  function automatic logic [31:0] io_word(input logic [31:0] a);
    return mem_word(a) ^ 32'hFFFF_0000;
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'((a / (LW * 4)) % SETS);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / (LW * 4 * SETS);
  endfunction

  task automatic step(input bit nreq, input logic [31:0] na, input bit nu, output bit acc);
    bit          e_aok, e_dok, e_arv, e_rr;
    logic [31:0] base;
    @(negedge clk);
    cyc++;
    if (busy) o_age++;
    icache_req      = nreq;
    icache_addr     = na;
    icache_uncached = nu;
    e_arv = busy && !o_hit && (o_age >= 2) && !o_ar_done;
    e_rr  = busy && o_ar_done && !o_refill_done;
    e_dok = busy && ((o_hit && o_age == 1) || o_refill_done);
    e_aok = nreq && (!busy || (o_hit && o_age == 1));
    mem_arready = e_arv && (o_arw == 0);
    mem_rvalid  = e_rr && (int'($urandom_range(99)) >= gap_pct);
    base = o_unc ? {o_addr[31:2], 2'b00} : (o_addr & ~32'(LW * 4 - 1));
    mem_rdata = !mem_rvalid ? 32'h0 :
                o_unc ? io_word(base) : mem_word(base + 32'(o_beat * 4));
    mem_rlast = mem_rvalid && (o_unc || o_beat == LW - 1);
    #1;
    check_eq("addr_ok", 32'(icache_addr_ok), 32'(e_aok));
    check_eq("data_ok", 32'(icache_data_ok), 32'(e_dok));
    check_eq("arvalid", 32'(mem_arvalid), 32'(e_arv));
    check_eq("rready", 32'(mem_rready), 32'(e_rr));
    if (e_arv) begin
      check_eq("araddr", mem_araddr, base);
      check_eq("arlen", 32'(mem_arlen), o_unc ? 32'h0 : 32'(LW - 1));
    end
    if (e_dok) begin
      check_eq("rdata", icache_rdata, o_exp);
      last_rdata = icache_rdata;
      last_lat   = cyc - o_acc_cyc;
      $display("[TB] resp addr=%h unc=%0d hit=%0d rdata=%h lat=%0d",
               o_addr, o_unc, o_hit, icache_rdata, last_lat);
      busy = 1'b0;
    end
    if (e_arv) begin
      if (o_arw == 0) begin
        o_ar_done = 1'b1;
        o_beat    = 0;
      end else begin
        o_arw--;
      end
    end
    if (mem_rvalid) begin
      if (mem_rlast) begin
        o_refill_done = 1'b1;
        if (!o_unc) begin
          ref_valid[set_of(o_addr)] = 1'b1;
          ref_tag[set_of(o_addr)]   = tag_of(o_addr);
        end
      end else begin
        o_beat++;
      end
    end
    acc = e_aok;
    if (e_aok) begin
      busy          = 1'b1;
      o_addr        = na;
      o_unc         = nu;
      o_age         = 0;
      o_hit         = !nu && ref_valid[set_of(na)] && (ref_tag[set_of(na)] == tag_of(na));
      o_ar_done     = 1'b0;
      o_refill_done = 1'b0;
      o_beat        = 0;
      o_arw         = int'($urandom_range(ar_hi, ar_lo));
      o_exp         = nu ? io_word(na) : mem_word(na);
      o_acc_cyc     = cyc;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    icache_req = 1'b0;
    mem_arready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rlast = 1'b0;
    mem_rdata = 32'h0;
    @(negedge clk);
    check_eq("rst_addr_ok", 32'(icache_addr_ok), 32'h0);
    check_eq("rst_data_ok", 32'(icache_data_ok), 32'h0);
    check_eq("rst_rdata", icache_rdata, 32'h0);
    check_eq("rst_arvalid", 32'(mem_arvalid), 32'h0);
    check_eq("rst_araddr", mem_araddr, 32'h0);
    check_eq("rst_arlen", 32'(mem_arlen), 32'h0);
    check_eq("rst_rready", 32'(mem_rready), 32'h0);
    busy = 1'b0;
    for (int s = 0; s < SETS; s++) ref_valid[s] = 1'b0;
    reset = 1'b0;
  endtask

  task automatic drain(input bit keep, input logic [31:0] a);
    bit acc;
    int n;
    n = 0;
    while (busy && n < 300) begin
      step(keep, a, 1'b0, acc);
      n++;
    end
    check_eq("drain_timeout", 32'(busy), 32'h0);
  endtask

  task automatic run_req(input logic [31:0] a, input bit u, input bit keep);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      step(1'b1, a, u, acc);
      n++;
    end
    check_eq("accept_timeout", 32'(acc), 32'h1);
    drain(keep, a ^ 32'h0000_2000);
  endtask

  logic [31:0] hs [4];
  logic [31:0] ra;
  bit          rq, ru, acc;
  int          idx, n;

  initial begin
    reset = 1'b1;
    icache_req = 1'b0; icache_addr = 32'h0; icache_uncached = 1'b0;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rdata = 32'h0;
    busy = 1'b0;
    do_reset();

    // Cold miss: zero-wait fill, requested word is beat 1
    run_req(32'h1FC0_0004, 1'b0, 1'b0);
    check_eq("cold_rdata", last_rdata, 32'hA1);
    check_eq("cold_lat", 32'(last_lat), 32'(3 + LW));

    // Hit stream: one accept per cycle
    hs[0] = 32'h1FC0_0000; hs[1] = 32'h1FC0_0004; hs[2] = 32'h1FC0_0008; hs[3] = 32'h1FC0_000C;
    idx = 0; n = 0;
    while (idx < 4 && n < 50) begin
      step(1'b1, hs[idx], 1'b0, acc);
      if (acc) idx++;
      n++;
    end
    check_eq("stream_cycles", 32'(n), 32'h4);
    drain(1'b0, 32'h0);
    check_eq("stream_last", last_rdata, 32'hA3);

    // Conflict on the same set, then the original line misses again
    run_req(32'h1FC0_1004, 1'b0, 1'b0);
    run_req(32'h1FC0_0004, 1'b0, 1'b0);
    check_eq("conflict_lat", 32'(last_lat), 32'(3 + LW));

    // Uncached read of a valid line must bypass and leave the line intact
    run_req(32'h1FC0_0008, 1'b1, 1'b0);
    check_eq("unc_rdata", last_rdata, 32'hFFFF_00A2);
    check_eq("unc_lat", 32'(last_lat), 32'h4);
    run_req(32'h1FC0_0008, 1'b0, 1'b0);
    check_eq("after_unc_rdata", last_rdata, 32'hA2);
    check_eq("after_unc_lat", 32'(last_lat), 32'h1);

    // Backpressure: AR held 5 cycles, gappy beats, request held high throughout
    ar_lo = 5; ar_hi = 5; gap_pct = 50;
    run_req(32'h1FC0_3018, 1'b0, 1'b1);
    ar_lo = 0; ar_hi = 0; gap_pct = 0;

    // Reset after two beats of a refill
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      step(1'b1, 32'h1FC0_2044, 1'b0, acc);
      n++;
    end
    n = 0;
    while (o_beat < 2 && n < 50) begin
      step(1'b0, 32'h0, 1'b0, acc);
      n++;
    end
    check_eq("mid_refill_beats", 32'(o_beat), 32'h2);
    do_reset();
    run_req(32'h1FC0_0004, 1'b0, 1'b0);
    check_eq("post_rst_lat", 32'(last_lat), 32'(3 + LW));
    run_req(32'h1FC0_2044, 1'b0, 1'b0);
    check_eq("post_rst_refill", 32'(last_lat), 32'(3 + LW));

    // Random traffic over a small address pool to mix hits, conflicts and bypasses
    ar_lo = 0; ar_hi = 3; gap_pct = 25;
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(2))
        0:       ra = 32'h1FC0_0000;
        1:       ra = 32'h1FC0_1000;
        default: ra = 32'h0040_0000;
      endcase
      ra = ra | ($urandom_range(3) << 4) | ($urandom_range(3) << 2) | $urandom_range(3);
      rq = ($urandom_range(99) < 70);
      ru = ($urandom_range(99) < 12);
      step(rq, ra, ru, acc);
    end
    drain(1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, blocking instruction cache. It is the responder end of the `icache_req/addr_ok/data_ok/rdata` protocol consumed by the fetch stages. It accepts fetch requests from pre-IF and returns exactly one `icache_data_ok`/`icache_rdata` per accepted request, in order. Misses and uncached fetches are refilled over a read-only AXI-style burst port toward the bus bridge.

## Interface
Parameters:
- `SETS`, 64: number of lines; power of two.
- `LINE_WORDS`, 4: 32-bit words per line; power of two, 2..16.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `icache_req`  in  1  fetch request valid
- `icache_addr`  in  32  physical byte address; bits [1:0] ignored
- `icache_uncached`  in  1  bypass the cache for this request (kseg1)
- `icache_addr_ok`  out  1  request accepted this cycle
- `icache_data_ok`  out  1  response valid; one-cycle pulse
- `icache_rdata`  out  32  instruction word; valid only when `icache_data_ok` is high
- `mem_arvalid`  out  1  burst read address valid
- `mem_araddr`  out  32  burst start address
- `mem_arlen`  out  4  beats minus 1: `LINE_WORDS-1` for a cached fill, 0 for uncached
- `mem_arready`  in  1  address accepted
- `mem_rvalid`  in  1  read beat valid
- `mem_rdata`  in  32  read beat data
- `mem_rlast`  in  1  last beat
- `mem_rready`  out  1  beat accept

## Operation
Address split:
- offset = addr[2+OW-1:2], with OW = log2(LINE_WORDS)
- index = next log2(SETS) bits
- tag = remaining upper bits

Arrays:
- Tag and data arrays are written synchronously and read combinationally from the registered request.
- Valid bits are flops cleared by reset.

States:
- **IDLE**: `icache_addr_ok = icache_req`. On acceptance, latch addr, uncached and offset, then go to LOOKUP.
- **LOOKUP**: hit = !uncached && valid[index] && tag match.
  - Hit: `icache_data_ok` = 1 with the selected word. `icache_addr_ok = icache_req`, so back-to-back hits sustain one request per cycle. If a new request is accepted, stay in LOOKUP; otherwise go to IDLE.
  - Miss or uncached: `icache_addr_ok` = 0; go to MISS.
- **MISS**: `mem_arvalid` = 1.
  - `mem_araddr` = line-aligned address (cached) or the exact word address (uncached).
  - On `mem_arready`, go to REFILL.
- **REFILL**: `mem_rready` = 1.
  - Cached: each beat is written at the index with a beat counter starting at 0. The beat whose number equals the latched offset is captured into a response register.
  - Uncached: the single beat is captured and no array is written.
  - On `mem_rvalid && mem_rlast`:
    - Cached: write the tag and set valid.
    - Go to RESP.
- **RESP**: `icache_data_ok` = 1 with the response register; `icache_addr_ok` = 0; go to IDLE.

Invariants:
- At most one request is outstanding; a second request is never accepted before the first one's `data_ok`.
- The cache never drops or suppresses a response. Cancellation after a flush is the consumer's job: the consumer discards the next `data_ok`.
- `mem_rlast` arriving before `LINE_WORDS` beats is a protocol error. It is not checked, and the line is still marked valid.
- Beats beyond `rlast` cannot occur.

## Timing
- Hit latency: request accepted at cycle T, `data_ok` at T+1.
- Miss latency: T+1 LOOKUP, then MISS for ≥1 cycle, then REFILL for ≥`LINE_WORDS` cycles, then RESP. With zero-wait memory, `data_ok` = T+3+`LINE_WORDS`. An uncached access with zero-wait memory gives `data_ok` at T+4.
- Reset values:
  - State IDLE; all valid bits 0.
  - `icache_addr_ok`, `icache_data_ok`, `mem_arvalid` and `mem_rready` are 0.
  - `icache_rdata` is 0, `mem_araddr` is 0, `mem_arlen` is 0.
- `mem_arvalid`, `mem_araddr` and `mem_arlen` are held stable until `mem_arready`.
- `icache_addr_ok` is combinational from `icache_req` and state/hit only. There is no path from `mem_*` to `icache_addr_ok`.
- Reset mid-refill returns to IDLE immediately and drops any in-flight beats. The bus bridge is reset by the same `reset`.
- Beat counter wraps at `LINE_WORDS` and is cleared on entry to REFILL.

## Structure
- The `icache_state_t` enum and the derived widths (`ICACHE_OW`, `ICACHE_IW`, `ICACHE_TW`) belong in the shared `cpu.svh` package.
- One sub-module, `icache_data_ram`:
  - SETS×LINE_WORDS×32 storage
  - one write port (index, word, data)
  - one combinational read port (index, word)
  - written as a behavioural array so it can be swapped for a BRAM wrapper later.
- Tag/valid logic lives in the top-level module.

## Test plan
- Cold miss: reset, then request 0x1FC0_0004 (cached). Memory returns 0xA0,0xA1,0xA2,0xA3 with zero wait. Expect `mem_arlen`=3 and `mem_araddr`=0x1FC0_0000; `data_ok` at T+7 with rdata 0xA1.
- Hit stream: after the fill, request 0x1FC0_0000/4/8/C on consecutive cycles. Expect `addr_ok` every cycle and `data_ok` on cycles T+1..T+4 returning 0xA0..0xA3.
- Conflict: request 0x1FC0_1004 (same index for SETS=64/LINE_WORDS=4, new tag). Expect a miss and refill. A later 0x1FC0_0004 misses again.
- Uncached: request 0x1FC0_0008 with `icache_uncached` while the line is valid. Expect a miss, `mem_arlen`=0, `mem_araddr`=0x1FC0_0008 and rdata from the bus. Tag and data arrays are unchanged.
- Backpressure: hold `mem_arready` low for 5 cycles and insert `mem_rvalid` gaps. Expect stable AR outputs, `icache_addr_ok` low throughout, and exactly one `data_ok`.
- Reset mid-REFILL after 2 beats. Expect IDLE next cycle, all outputs 0, and the same address missing again afterwards.
